// File: rtl/hack_pkg.sv
// Shared types for the Hack boot loader: FSM state encoding, error codes and
// per-state decode helpers.
package hack_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_LO  = 3'd1,
        S_LEN_HI  = 3'd2,
        S_DATA_LO = 3'd3,
        S_DATA_HI = 3'd4,
        S_CHECK   = 3'd5,
        S_RUN     = 3'd6,
        S_ERROR   = 3'd7
    } boot_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    function automatic logic state_rx_ready(input boot_state_e s);
        case (s)
            S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHECK: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

    // LEN_LO is excluded: the loader may wait forever for an image to begin.
    function automatic logic state_times_out(input boot_state_e s);
        case (s)
            S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHECK: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/boot_timeout.sv
// Inter-byte gap watchdog: reloads on clear, counts down while enabled and
// flags expiry on the TIMEOUT-th consecutive idle cycle.
module boot_timeout #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LOAD = CW'(TIMEOUT);
    localparam logic [CW-1:0]  LAST = CW'(1);

    logic [CW-1:0] cnt_q;

    // Down-counter; holds at LAST so expiry stays visible until the FSM reacts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= LOAD;
        end else if (clear_i) begin
            cnt_q <= LOAD;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q - LAST;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/hack_boot_loader.sv
// Boot sequencer for the Hack CPU: receives a length-prefixed, checksummed
// program image byte by byte, writes it to instruction ROM, then releases the CPU.
module hack_boot_loader
    import hack_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int MAX_WORDS = 32768,
    parameter int TIMEOUT   = 50000
) (
    input  logic              CLK_CPU,
    input  logic              reset_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [15:0]       words_loaded
);

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    boot_state_e       state_q, state_d;
    logic [1:0]        err_q, err_d;
    logic [7:0]        len_lo_q;
    logic [15:0]       len_q;
    logic [7:0]        lo_q;
    logic [7:0]        sum_q;
    logic [15:0]       word_cnt_q;
    logic              rx_ready_q;
    logic              rom_we_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [15:0]       rom_wdata_q;
    logic              cpu_reset_q;
    logic              done_q;

    logic              accept_s;
    logic [15:0]       len_s;
    logic              last_word_s;
    logic              restart_s;
    logic              tmo_enable_s;
    logic              tmo_clear_s;
    logic              expired_s;

    assign accept_s     = rx_valid && rx_ready_q;
    assign len_s        = {rx_data, len_lo_q};
    assign last_word_s  = ((word_cnt_q + 16'd1) == len_q);
    assign restart_s    = start && ((state_q == S_RUN) || (state_q == S_ERROR));
    assign tmo_enable_s = state_times_out(state_q);
    assign tmo_clear_s  = accept_s || !tmo_enable_s;

    boot_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (CLK_CPU),
        .rst_ni    (reset_n),
        .clear_i   (tmo_clear_s),
        .enable_i  (tmo_enable_s),
        .expired_o (expired_s)
    );

    // Next-state and error-code decode; an accepted byte always beats expiry.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept_s) begin
                    state_d = S_LEN_HI;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_HI: begin
                if (accept_s) begin
                    if (len_s == 16'd0) begin
                        state_d = S_CHECK;
                    end else if ({1'b0, len_s} > MAX_LEN) begin
                        state_d = S_ERROR;
                        err_d   = ERR_LEN;
                    end else begin
                        state_d = S_DATA_LO;
                    end
                end else if (expired_s) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    state_d = state_q;
                end
            end
            S_DATA_LO: begin
                if (accept_s) begin
                    state_d = S_DATA_HI;
                end else if (expired_s) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    state_d = state_q;
                end
            end
            S_DATA_HI: begin
                if (accept_s) begin
                    if (last_word_s) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA_LO;
                    end
                end else if (expired_s) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    state_d = state_q;
                end
            end
            S_CHECK: begin
                if (accept_s) begin
                    if (rx_data == sum_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = ERR_CHK;
                    end
                end else if (expired_s) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN, S_ERROR: begin
                if (restart_s) begin
                    state_d = S_LEN_LO;
                    err_d   = ERR_NONE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge CLK_CPU or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            err_q       <= ERR_NONE;
            len_lo_q    <= 8'd0;
            len_q       <= 16'd0;
            lo_q        <= 8'd0;
            sum_q       <= 8'd0;
            word_cnt_q  <= 16'd0;
            rx_ready_q  <= 1'b0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= 16'd0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            rx_ready_q  <= state_rx_ready(state_d);
            cpu_reset_q <= (state_d != S_RUN);
            done_q      <= (state_d == S_RUN);
            rom_we_q    <= 1'b0;

            if (accept_s) begin
                case (state_q)
                    S_LEN_LO: begin
                        len_lo_q <= rx_data;
                    end
                    S_LEN_HI: begin
                        len_q <= len_s;
                    end
                    S_DATA_LO: begin
                        lo_q  <= rx_data;
                        sum_q <= sum_q + rx_data;
                    end
                    S_DATA_HI: begin
                        rom_we_q    <= 1'b1;
                        rom_wdata_q <= {rx_data, lo_q};
                        rom_addr_q  <= ADDR_W'(word_cnt_q);
                        word_cnt_q  <= word_cnt_q + 16'd1;
                        sum_q       <= sum_q + rx_data;
                    end
                    default: begin
                        len_lo_q <= len_lo_q;
                    end
                endcase
            end else if (restart_s) begin
                sum_q      <= 8'd0;
                word_cnt_q <= 16'd0;
            end else begin
                sum_q <= sum_q;
            end
        end
    end

    assign rx_ready     = rx_ready_q;
    assign rom_we       = rom_we_q;
    assign rom_addr     = rom_addr_q;
    assign rom_wdata    = rom_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign err_code     = err_q;
    assign words_loaded = word_cnt_q;

endmodule

// File: tb/tb_hack_boot_loader.sv
// Self-checking bench for hack_boot_loader: directed image scenarios plus
// randomized images/gaps checked against a byte-stream parsing model.
module tb_hack_boot_loader;
    import hack_pkg::*;

    localparam int ADDR_W    = 15;
    localparam int MAX_WORDS = 4;
    localparam int TIMEOUT   = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              cpu_reset;
    logic              done;
    logic [1:0]        err_code;
    logic [15:0]       words_loaded;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    logic [30:0] obs_q[$];
    logic [30:0] exp_q[$];

    hack_boot_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLK_CPU      (clk),
        .reset_n      (reset_n),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rom_we       (rom_we),
        .rom_addr     (rom_addr),
        .rom_wdata    (rom_wdata),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // ROM write monitor
    always @(negedge clk) begin
        if (rom_we === 1'b1) obs_q.push_back({rom_addr, rom_wdata});
    end

    task automatic send_byte(input logic [7:0] b, input int tries, output bit ok);
        ok = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < tries && !ok; i++) begin
            if (rx_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int g);
        rx_valid = 1'b0;
        repeat (g) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference: parse tx_q as an image and derive outcome and ROM writes.
    task automatic model(output int consumed, output logic [1:0] e_err, output int e_words);
        int n;
        int sum;
        exp_q.delete();
        n = int'({tx_q[1], tx_q[0]});
        if (n > MAX_WORDS) begin
            consumed = 2;
            e_err    = 2'd2;
            e_words  = 0;
        end else begin
            sum = 0;
            for (int i = 0; i < n; i++) begin
                sum = sum + int'(tx_q[2 + 2 * i]) + int'(tx_q[3 + 2 * i]);
                exp_q.push_back({15'(i), tx_q[3 + 2 * i], tx_q[2 + 2 * i]});
            end
            consumed = 2 * n + 3;
            e_err    = (int'(tx_q[2 + 2 * n]) == (sum % 256)) ? 2'd0 : 2'd1;
            e_words  = n;
        end
    endtask

    task automatic run_scenario(input string name, input int max_gap);
        int         consumed;
        int         e_words;
        logic [1:0] e_err;
        bit         ok;
        model(consumed, e_err, e_words);
        obs_q.delete();
        for (int i = 0; i < consumed; i++) begin
            if (i > 0 && max_gap > 0) idle($urandom_range(0, max_gap));
            send_byte(tx_q[i], 64, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s accept byte %0d: not accepted, expected accepted", name, i);
            end
        end
        if (e_err == 2'd2) begin
            send_byte(8'h55, 8, ok);
            checks++;
            if (ok) begin
                errors++;
                $display("FAIL %s byte after LEN_HI: accepted, expected refused", name);
            end
        end
        checks++;
        if (err_code !== e_err) begin
            errors++;
            $display("FAIL %s err_code: got %0d expected %0d", name, err_code, e_err);
        end
        checks++;
        if (done !== (e_err == 2'd0)) begin
            errors++;
            $display("FAIL %s done: got %b expected %b", name, done, (e_err == 2'd0));
        end
        checks++;
        if (cpu_reset !== (e_err != 2'd0)) begin
            errors++;
            $display("FAIL %s cpu_reset: got %b expected %b", name, cpu_reset, (e_err != 2'd0));
        end
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s rx_ready: got %b expected 0", name, rx_ready);
        end
        checks++;
        if (words_loaded !== 16'(e_words)) begin
            errors++;
            $display("FAIL %s words_loaded: got %0d expected %0d", name, words_loaded, e_words);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s write count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s write %0d: got addr %0d data %h expected addr %0d data %h",
                         name, i, obs_q[i][30:16], obs_q[i][15:0], exp_q[i][30:16], exp_q[i][15:0]);
            end
        end
    endtask

    task automatic load_basic(input logic [7:0] chk);
        // payload sum 34+12+CD+AB = 0x1BE, so the valid CHK is 0xBE
        tx_q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, chk};
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cpu_reset, rx_ready, rom_we, rom_addr, rom_wdata, done, err_code, words_loaded} !==
            {1'b1, 1'b0, 1'b0, 15'd0, 16'd0, 1'b0, 2'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset values: got cpu_reset=%b rx_ready=%b we=%b addr=%0d wdata=%h done=%b err=%0d words=%0d expected 1 0 0 0 0000 0 0 0",
                     cpu_reset, rx_ready, rom_we, rom_addr, rom_wdata, done, err_code, words_loaded);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL idle exit: got rx_ready=%b cpu_reset=%b expected 1 1", rx_ready, cpu_reset);
        end
    endtask

    task automatic test_basic();
        load_basic(8'hBE);
        run_scenario("basic", 0);
    endtask

    task automatic test_bad_checksum();
        pulse_start();
        load_basic(8'hBF);
        run_scenario("bad_chk", 0);
        pulse_start();
        checks++;
        if (err_code !== 2'd0 || words_loaded !== 16'd0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL start clear: got err=%0d words=%0d rx_ready=%b expected 0 0 1",
                     err_code, words_loaded, rx_ready);
        end
        load_basic(8'hBE);
        run_scenario("after_start", 0);
    endtask

    task automatic test_lengths();
        pulse_start();
        tx_q = '{8'h00, 8'h00, 8'h00};
        run_scenario("zero_len", 0);
        pulse_start();
        tx_q = '{8'h05, 8'h00, 8'h11, 8'h22};
        run_scenario("len_too_big", 0);
        pulse_start();
        tx_q = '{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
        run_scenario("len_max", 0);
    endtask

    task automatic test_timeout();
        bit ok;
        pulse_start();
        send_byte(8'h01, 8, ok);
        send_byte(8'h00, 8, ok);
        send_byte(8'h34, 8, ok);
        idle(TIMEOUT - 1);
        checks++;
        if (err_code !== 2'd0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout early: got err=%0d rx_ready=%b expected 0 1", err_code, rx_ready);
        end
        idle(1);
        checks++;
        if (err_code !== 2'd3 || rx_ready !== 1'b0 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL timeout: got err=%0d rx_ready=%b cpu_reset=%b expected 3 0 1",
                     err_code, rx_ready, cpu_reset);
        end
        pulse_start();
        idle(3 * TIMEOUT);
        checks++;
        if (err_code !== 2'd0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL len_lo wait: got err=%0d rx_ready=%b expected 0 1", err_code, rx_ready);
        end
        obs_q.delete();
        send_byte(8'h01, 8, ok);
        send_byte(8'h00, 8, ok);
        send_byte(8'h34, 8, ok);
        idle(TIMEOUT - 1);
        send_byte(8'h12, 8, ok);
        send_byte(8'h46, 8, ok);
        checks++;
        if (done !== 1'b1 || err_code !== 2'd0 || obs_q.size() != 1) begin
            errors++;
            $display("FAIL gap below timeout: got done=%b err=%0d writes=%0d expected 1 0 1",
                     done, err_code, obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== {15'd0, 16'h1234}) begin
                errors++;
                $display("FAIL gap write: got %h expected %h", obs_q[0], {15'd0, 16'h1234});
            end
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        pulse_start();
        obs_q.delete();
        send_byte(8'h01, 8, ok);
        send_byte(8'h00, 8, ok);
        send_byte(8'h11, 8, ok);
        pulse_start();
        send_byte(8'h22, 8, ok);
        send_byte(8'h33, 8, ok);
        checks++;
        if (done !== 1'b1 || obs_q.size() != 1 || words_loaded !== 16'd1) begin
            errors++;
            $display("FAIL start mid-download: got done=%b writes=%0d words=%0d expected 1 1 1",
                     done, obs_q.size(), words_loaded);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        pulse_start();
        send_byte(8'h02, 8, ok);
        send_byte(8'h00, 8, ok);
        send_byte(8'h34, 8, ok);
        send_byte(8'h12, 8, ok);
        send_byte(8'hCD, 8, ok);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({cpu_reset, rx_ready, rom_we, rom_addr, rom_wdata, done, err_code, words_loaded} !==
            {1'b1, 1'b0, 1'b0, 15'd0, 16'd0, 1'b0, 2'd0, 16'd0}) begin
            errors++;
            $display("FAIL async reset: got cpu_reset=%b rx_ready=%b we=%b addr=%0d wdata=%h done=%b err=%0d words=%0d expected 1 0 0 0 0000 0 0 0",
                     cpu_reset, rx_ready, rom_we, rom_addr, rom_wdata, done, err_code, words_loaded);
        end
        @(negedge clk);
        reset_n = 1'b1;
        load_basic(8'hBE);
        run_scenario("after_reset", 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int          n;
            int          sum;
            logic [7:0]  b;
            pulse_start();
            n = $urandom_range(0, MAX_WORDS + 1);
            tx_q.delete();
            tx_q.push_back(8'(n));
            tx_q.push_back(8'd0);
            sum = 0;
            for (int i = 0; i < 2 * n; i++) begin
                b = 8'($urandom_range(0, 255));
                sum = sum + int'(b);
                tx_q.push_back(b);
            end
            if ($urandom_range(0, 3) == 0) tx_q.push_back(8'((sum + $urandom_range(1, 255)) % 256));
            else                           tx_q.push_back(8'(sum % 256));
            run_scenario($sformatf("random%0d", it), TIMEOUT - 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_lengths();
        test_timeout();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
